// File: rtl/cr_unit_pkg.sv
// Condition-register unit shared definitions: op encodings, field geometry,
// and compare-result bit positions inside a 4-bit field (offset 0 = MSB).
package cr_unit_pkg;

    localparam int CR_FIELD_W = 4;

    // Bit offsets inside one field, counted from the field's MSB.
    localparam int CR_LT = 0;
    localparam int CR_GT = 1;
    localparam int CR_EQ = 2;
    localparam int CR_SO = 3;

    typedef enum logic [3:0] {
        CR_OP_AND   = 4'd0,
        CR_OP_OR    = 4'd1,
        CR_OP_XOR   = 4'd2,
        CR_OP_NAND  = 4'd3,
        CR_OP_NOR   = 4'd4,
        CR_OP_EQV   = 4'd5,
        CR_OP_ANDC  = 4'd6,
        CR_OP_ORC   = 4'd7,
        CR_OP_MCRF  = 4'd8,
        CR_OP_MTCRF = 4'd9
    } cr_op_e;

    // Single-bit logic ops occupy the low half of the encoding space.
    function automatic logic is_logic_op(input logic [3:0] op);
        return (op <= 4'(CR_OP_ORC));
    endfunction

endpackage

// File: rtl/cr_bit_logic.sv
// Combinational two-input CR bit operation selected by op code.
// Non-logic op codes produce 0; the caller never writes in that case.
module cr_bit_logic
    import cr_unit_pkg::*;
(
    input  logic [3:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    // Evaluate the selected boolean function of the two source bits.
    always_comb begin
        y = 1'b0;
        case (op)
            CR_OP_AND:  y = a & b;
            CR_OP_OR:   y = a | b;
            CR_OP_XOR:  y = a ^ b;
            CR_OP_NAND: y = ~(a & b);
            CR_OP_NOR:  y = ~(a | b);
            CR_OP_EQV:  y = ~(a ^ b);
            CR_OP_ANDC: y = a & ~b;
            CR_OP_ORC:  y = a | ~b;
            default:    y = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr_field_unit.sv
// Condition-register unit: NFIELD x 4-bit CR with a one-stage op pipeline
// (bit logic, mcrf, mtcrf) and an independent compare-result field port.
// Bit numbering is big-endian: CR bit 0 is cr[CRW-1], field f is the nibble
// starting at cr[CRW-1-4f]. Out-of-range indices read 0 and never write.
//
// Handshake: a request transfers on a clk edge where req_valid && req_ready.
// req_valid may drop at any time; req_ready never depends on req_valid.
//
// Build option: define CR_FWD_EN to capture operands from the CR value that
// will exist after the current edge (S1 result > cmp write > CR), which lets
// the unit take a request every cycle. Without it, req_ready is held low
// while an op is in S1 or a compare write is being presented.
module cr_field_unit
    import cr_unit_pkg::*;
#(
    parameter int NFIELD = 8,
    parameter int IDX_W  = 5,
    parameter int FLD_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [IDX_W-1:0]    req_bt,
    input  logic [IDX_W-1:0]    req_ba,
    input  logic [IDX_W-1:0]    req_bb,
    input  logic [NFIELD-1:0]   req_fxm,
    input  logic [4*NFIELD-1:0] req_wd,
    input  logic                cmp_valid,
    input  logic [FLD_W-1:0]    cmp_bf,
    input  logic [3:0]          cmp_val,
    output logic [4*NFIELD-1:0] rd,
    output logic                done
);

    localparam int CRW = 4 * NFIELD;
    localparam logic [CRW-1:0] TOP_BIT = {1'b1, {(CRW-1){1'b0}}};
    localparam logic [CRW-1:0] TOP_FLD = {{CR_FIELD_W{1'b1}}, {(CRW-CR_FIELD_W){1'b0}}};

    // One-hot mask of CR bit idx; zero when idx is out of range.
    function automatic logic [CRW-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        logic [CRW-1:0] m;
        m = '0;
        for (int i = 0; i < CRW; i++) begin
            if (idx == IDX_W'(i)) m = TOP_BIT >> i;
        end
        return m;
    endfunction

    // Four-bit mask covering field f; zero when f is out of range.
    function automatic logic [CRW-1:0] field_mask(input logic [IDX_W-1:0] f);
        logic [CRW-1:0] m;
        m = '0;
        for (int i = 0; i < NFIELD; i++) begin
            if (f == IDX_W'(i)) m = TOP_FLD >> (4 * i);
        end
        return m;
    endfunction

    function automatic logic get_bit(input logic [CRW-1:0] v, input logic [IDX_W-1:0] idx);
        return |(v & bit_mask(idx));
    endfunction

    function automatic logic [3:0] get_field(input logic [CRW-1:0] v, input logic [IDX_W-1:0] f);
        logic [CRW-1:0] t;
        logic [3:0]     r;
        r = 4'h0;
        for (int i = 0; i < NFIELD; i++) begin
            if (f == IDX_W'(i)) begin
                t = v << (4 * i);
                r = t[CRW-1 -: 4];
            end
        end
        return r;
    endfunction

    logic [CRW-1:0]    cr;
    logic [CRW-1:0]    cr_next;
    logic [CRW-1:0]    op_view;
    logic [CRW-1:0]    cmp_mask;
    logic [CRW-1:0]    cmp_data;
    logic [CRW-1:0]    s1_mask;
    logic [CRW-1:0]    s1_data;
    logic              accept;

    // S1 holds the operands captured at accept time.
    logic              s1_valid;
    logic [3:0]        s1_op;
    logic              s1_a;
    logic              s1_b;
    logic [3:0]        s1_src;
    logic [IDX_W-1:0]  s1_bt;
    logic [NFIELD-1:0] s1_fxm;
    logic [CRW-1:0]    s1_wd;
    logic              s1_y;

    assign rd     = cr;
    assign accept = req_valid & req_ready;

    cr_bit_logic u_bit_logic (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .y  (s1_y)
    );

    // Compare-result write: whole target field replaced with cmp_val.
    always_comb begin
        cmp_mask = '0;
        cmp_data = '0;
        if (cmp_valid) begin
            cmp_mask = field_mask(IDX_W'(cmp_bf));
            cmp_data = {NFIELD{cmp_val}} & cmp_mask;
        end
    end

    // S1 result: which CR bits the pending op writes and with what values.
    always_comb begin
        s1_mask = '0;
        s1_data = '0;
        if (s1_valid) begin
            if (is_logic_op(s1_op)) begin
                s1_mask = bit_mask(s1_bt);
                s1_data = {CRW{s1_y}} & s1_mask;
            end else if (s1_op == 4'(CR_OP_MCRF)) begin
                s1_mask = field_mask(IDX_W'(s1_bt[IDX_W-1:2]));
                s1_data = {NFIELD{s1_src}} & s1_mask;
            end else if (s1_op == 4'(CR_OP_MTCRF)) begin
                for (int i = 0; i < NFIELD; i++) begin
                    if (s1_fxm[i]) s1_mask = s1_mask | (TOP_FLD >> (4 * i));
                end
                s1_data = s1_wd & s1_mask;
            end
        end
    end

    // Merge both write sources; S1 is younger and wins on overlapping bits.
    always_comb begin
        cr_next = (cr & ~cmp_mask & ~s1_mask) | (cmp_data & ~s1_mask) | s1_data;
    end

`ifdef CR_FWD_EN
    // Operands see this edge's writes, so the unit never has to stall.
    always_comb begin
        op_view   = cr_next;
        req_ready = 1'b1;
    end
`else
    // Operands come straight from CR, so wait until no write is in flight.
    always_comb begin
        op_view   = cr;
        req_ready = ~s1_valid & ~cmp_valid;
    end
`endif

    // CR register and result-written pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr   <= '0;
            done <= 1'b0;
        end else begin
            cr   <= cr_next;
            done <= s1_valid;
        end
    end

    // S1 capture register: operands are resolved to values at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 4'h0;
            s1_a     <= 1'b0;
            s1_b     <= 1'b0;
            s1_src   <= 4'h0;
            s1_bt    <= '0;
            s1_fxm   <= '0;
            s1_wd    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= req_op;
                s1_a   <= get_bit(op_view, req_ba);
                s1_b   <= get_bit(op_view, req_bb);
                s1_src <= get_field(op_view, IDX_W'(req_ba[IDX_W-1:2]));
                s1_bt  <= req_bt;
                s1_fxm <= req_fxm;
                s1_wd  <= req_wd;
            end
        end
    end

endmodule
